// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle between the producer, the write controller and the read-side logic.
// The slave modport is the controller's view; the master modport is the producer/read-side view.
interface fifo_wr_ctrl_if #(
    parameter int BUS_WIDTH = 66,
    parameter int F_DEPTH   = 4,
    parameter int P_SIZE    = 3
);
    logic                 wr_en;
    logic [BUS_WIDTH-1:0] wr_data;
    logic [P_SIZE-1:0]    sync_rd_gray_ptr;
    logic [P_SIZE-1:0]    wr_gray_ptr;
    logic                 wr_full;
    logic                 wr_overflow;
    logic [P_SIZE-1:0]    wr_level;
    logic [BUS_WIDTH-1:0] mem [F_DEPTH];

    modport slave (
        input  wr_en, wr_data, sync_rd_gray_ptr,
        output wr_gray_ptr, wr_full, wr_overflow, wr_level, mem
    );

    modport master (
        output wr_en, wr_data, sync_rd_gray_ptr,
        input  wr_gray_ptr, wr_full, wr_overflow, wr_level, mem
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write half of an async FIFO: binary/Gray write pointer, registered full flag,
// sticky overflow, write-side level and the storage array exported to the read side.
module fifo_wr_ctrl #(
    parameter int BUS_WIDTH = 66,
    parameter int F_DEPTH   = 4,
    parameter int P_SIZE    = 3
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_wr_ctrl_if.slave     bus
);
    localparam int ADDR_W = P_SIZE - 1;
    // Full when our next Gray pointer equals the read pointer with its two MSBs flipped.
    localparam logic [P_SIZE-1:0] FULL_MASK = P_SIZE'(3) << (P_SIZE - 2);

    logic [P_SIZE-1:0] wptr_bin_q, wptr_bin_d;
    logic [P_SIZE-1:0] wr_gray_q, wr_gray_d;
    logic [P_SIZE-1:0] rd_bin;
    logic              wr_full_q, wr_full_d;
    logic              wr_ovf_q, wr_ovf_d;
    logic              wr_accept;

    genvar gi;

    generate
        for (gi = 0; gi < P_SIZE; gi++) begin : g_gray2bin
            assign rd_bin[gi] = ^(bus.sync_rd_gray_ptr >> gi);
        end
    endgenerate

    always_comb begin
        wr_accept  = bus.wr_en & ~wr_full_q;
        wptr_bin_d = wptr_bin_q + P_SIZE'(wr_accept);
        wr_gray_d  = (wptr_bin_d >> 1) ^ wptr_bin_d;
        wr_full_d  = (wr_gray_d == (bus.sync_rd_gray_ptr ^ FULL_MASK));
        wr_ovf_d   = wr_ovf_q | (bus.wr_en & wr_full_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_bin_q <= '0;
            wr_gray_q  <= '0;
            wr_full_q  <= 1'b0;
            wr_ovf_q   <= 1'b0;
        end else begin
            wptr_bin_q <= wptr_bin_d;
            wr_gray_q  <= wr_gray_d;
            wr_full_q  <= wr_full_d;
            wr_ovf_q   <= wr_ovf_d;
        end
    end

    // One register per word so the whole array can be cleared by the async reset.
    generate
        for (gi = 0; gi < F_DEPTH; gi++) begin : g_mem
            logic [BUS_WIDTH-1:0] word_q;

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    word_q <= '0;
                end else if (wr_accept && (wptr_bin_q[ADDR_W-1:0] == ADDR_W'(gi))) begin
                    word_q <= bus.wr_data;
                end
            end

            assign bus.mem[gi] = word_q;
        end
    endgenerate

    assign bus.wr_gray_ptr = wr_gray_q;
    assign bus.wr_full     = wr_full_q;
    assign bus.wr_overflow = wr_ovf_q;
    assign bus.wr_level    = wptr_bin_q - rd_bin;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: stimulus pushes hand-computed post-edge state
// into a queue, a monitor pops and compares one entry after every clock edge.
module tb_fifo_wr_ctrl;
    localparam int BW = 66;
    localparam int FD = 4;
    localparam int PS = 3;

    localparam logic [BW-1:0] WA = 66'h2_0000_0000_0000_00A1;
    localparam logic [BW-1:0] WB = 66'h1_FFFF_0000_0000_00B2;
    localparam logic [BW-1:0] WC = 66'h3_0000_1234_0000_00C3;
    localparam logic [BW-1:0] WD = 66'h0_8000_0000_0000_00D4;
    localparam logic [BW-1:0] WE = 66'h2_5555_5555_5555_55E5;
    localparam logic [BW-1:0] WF = 66'h1_AAAA_AAAA_AAAA_AAF6;
    localparam logic [BW-1:0] Z  = '0;

    typedef struct {
        int                    idx;
        logic                  en;
        logic [BW-1:0]         d;
        logic [PS-1:0]         rd;
        logic [PS-1:0]         gray;
        logic                  full;
        logic                  ovf;
        logic [PS-1:0]         lvl;
        logic [FD-1:0][BW-1:0] m;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total  = 0;
    int   passed = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    fifo_wr_ctrl_if #(.BUS_WIDTH(BW), .F_DEPTH(FD), .P_SIZE(PS)) bus ();

    fifo_wr_ctrl #(.BUS_WIDTH(BW), .F_DEPTH(FD), .P_SIZE(PS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [BW-1:0] ww(input int n);
        return {2'b01, 32'hC0DE_0000, 24'h0, 8'(n)};
    endfunction

    task automatic chk(input string name, input int idx, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
        else
            passed++;
    endtask

    task automatic add(input logic en, input logic [BW-1:0] d, input logic [PS-1:0] rd,
                       input logic [PS-1:0] gray, input logic full, input logic ovf,
                       input logic [PS-1:0] lvl, input logic [BW-1:0] m3, input logic [BW-1:0] m2,
                       input logic [BW-1:0] m1, input logic [BW-1:0] m0);
        vec_t v;
        v.idx = vecs.size(); v.en = en; v.d = d; v.rd = rd; v.gray = gray;
        v.full = full; v.ovf = ovf; v.lvl = lvl;
        v.m[3] = m3; v.m[2] = m2; v.m[1] = m1; v.m[0] = m0;
        vecs.push_back(v);
    endtask

    task automatic check_state(input string tag, input logic [PS-1:0] gray, input logic full,
                               input logic ovf, input logic [PS-1:0] lvl, input logic [FD-1:0][BW-1:0] m, input int idx);
        chk({tag, "_gray"},  idx, BW'(bus.wr_gray_ptr), BW'(gray));
        chk({tag, "_full"},  idx, BW'(bus.wr_full),     BW'(full));
        chk({tag, "_ovf"},   idx, BW'(bus.wr_overflow), BW'(ovf));
        chk({tag, "_level"}, idx, BW'(bus.wr_level),    BW'(lvl));
        for (int i = 0; i < FD; i++)
            chk($sformatf("%s_mem%0d", tag, i), idx, bus.mem[i], m[i]);
    endtask

    task automatic run_vecs();
        while (vecs.size() > 0) begin
            vec_t v;
            v = vecs.pop_front();
            @(negedge CLK);
            bus.wr_en            = v.en;
            bus.wr_data          = v.d;
            bus.sync_rd_gray_ptr = v.rd;
            exp_q.push_back(v);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: one expected entry per clock edge while stimulus is active.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                vec_t e;
                e = exp_q.pop_front();
                check_state("op", e.gray, e.full, e.ovf, e.lvl, e.m, e.idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FD-1:0][BW-1:0] zm;
        zm = '0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.sync_rd_gray_ptr = '0;

        // Reset without any clock edge.
        #1 RST = 1'b0;
        #1 check_state("rst0", 3'b000, 1'b0, 1'b0, 3'd0, zm, -1);
        @(negedge CLK);
        RST = 1'b1;

        // Fill, overflow, drain/refill, same-edge race.
        //   en  data rd      gray    full  ovf   lvl   mem3 mem2 mem1 mem0
        add(1'b1, WA, 3'b000, 3'b001, 1'b0, 1'b0, 3'd1, Z,  Z,  Z,  WA);
        add(1'b1, WB, 3'b000, 3'b011, 1'b0, 1'b0, 3'd2, Z,  Z,  WB, WA);
        add(1'b1, WC, 3'b000, 3'b010, 1'b0, 1'b0, 3'd3, Z,  WC, WB, WA);
        add(1'b1, WD, 3'b000, 3'b110, 1'b1, 1'b0, 3'd4, WD, WC, WB, WA);
        add(1'b1, WE, 3'b000, 3'b110, 1'b1, 1'b1, 3'd4, WD, WC, WB, WA);
        add(1'b0, WE, 3'b001, 3'b110, 1'b0, 1'b1, 3'd3, WD, WC, WB, WA);
        add(1'b1, WE, 3'b001, 3'b111, 1'b1, 1'b1, 3'd4, WD, WC, WB, WE);
        add(1'b1, WF, 3'b011, 3'b111, 1'b0, 1'b1, 3'd3, WD, WC, WB, WE);
        add(1'b1, WF, 3'b011, 3'b101, 1'b1, 1'b1, 3'd4, WD, WC, WF, WE);
        run_vecs();
        drain();

        // Async reset mid-burst: everything clears at once and the pending write is dropped.
        @(negedge CLK);
        bus.wr_en = 1'b1;
        bus.wr_data = WA;
        #2;
        RST = 1'b0;
        bus.sync_rd_gray_ptr = '0;
        #1 check_state("rst1", 3'b000, 1'b0, 1'b0, 3'd0, zm, -2);
        @(posedge CLK);
        #1 check_state("rst1_edge", 3'b000, 1'b0, 1'b0, 3'd0, zm, -3);
        @(negedge CLK);
        RST = 1'b1;
        bus.wr_en = 1'b0;

        // Wrap: eight writes with the read pointer one behind.
        add(1'b1, ww(1), 3'b000, 3'b001, 1'b0, 1'b0, 3'd1, Z,     Z,     Z,     ww(1));
        add(1'b1, ww(2), 3'b001, 3'b011, 1'b0, 1'b0, 3'd1, Z,     Z,     ww(2), ww(1));
        add(1'b1, ww(3), 3'b011, 3'b010, 1'b0, 1'b0, 3'd1, Z,     ww(3), ww(2), ww(1));
        add(1'b1, ww(4), 3'b010, 3'b110, 1'b0, 1'b0, 3'd1, ww(4), ww(3), ww(2), ww(1));
        add(1'b1, ww(5), 3'b110, 3'b111, 1'b0, 1'b0, 3'd1, ww(4), ww(3), ww(2), ww(5));
        add(1'b1, ww(6), 3'b111, 3'b101, 1'b0, 1'b0, 3'd1, ww(4), ww(3), ww(6), ww(5));
        add(1'b1, ww(7), 3'b101, 3'b100, 1'b0, 1'b0, 3'd1, ww(4), ww(7), ww(6), ww(5));
        add(1'b1, ww(8), 3'b100, 3'b000, 1'b0, 1'b0, 3'd1, ww(8), ww(7), ww(6), ww(5));
        run_vecs();
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
